pattern_gen_multi: RTL

- Parametrised successor to the fixed-resolution colour-bar source that feeds the rgb2dvi HDMI encoder.
- Generates programmable video timing (HS/VS/DE) plus one of four run-time-selectable test patterns, with parametrised resolution and colour depth.
- Runs on the pixel clock; outputs connect directly to the encoder's pixel-data and sync inputs.

---
 rtl/pattern_gen_pkg.sv | 34 +++
 rtl/video_timing_gen.sv | 89 ++++++++
 rtl/pattern_gen_multi.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// pattern_gen_pkg
//   Shared types and helpers for the multi-pattern video source.
//   - mode_e   : run-time pattern select (bars, checker, gradient, solid)
//   - bar_mask : 8-entry colour-bar table as {R,G,B} on/off masks; the
//                consuming module expands each bit to full scale.
// ---------------------------------------------------------------------------
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      3'd7:    m = 3'b000;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Free-running horizontal/vertical counters and the unregistered region
//   decodes derived from them.
//   Ports:
//     clk, rst_n   : pixel clock, asynchronous active-low reset
//     hcnt, vcnt   : current pixel/line counters (0..TOTAL-1)
//     active       : inside the visible area
//     hs, vs       : inside the sync pulse (polarity applied by the consumer)
//     h_active     : inside the visible part of any line
//     line_end     : last clock of a line
//     frame_end    : last clock of a frame (mode latch / scroll point)
//     frame_first  : pixel (0,0)
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          h_active,
  output logic          hs,
  output logic          vs,
  output logic          line_end,
  output logic          frame_end,
  output logic          frame_first
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          last_line_s;

  assign line_end    = (hcnt_q == HW'(H_TOTAL - 1));
  assign last_line_s = (vcnt_q == VW'(V_TOTAL - 1));
  assign frame_end   = line_end && last_line_s;
  assign frame_first = (hcnt_q == '0) && (vcnt_q == '0);
  assign h_active    = (hcnt_q < HW'(H_ACTIVE));
  assign active      = h_active && (vcnt_q < VW'(V_ACTIVE));
  // Inclusive upper bounds keep the constants inside the counter width.
  assign hs = (hcnt_q >= HW'(H_ACTIVE + H_FP)) &&
              (hcnt_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
  // vcnt only moves on line_end, so vs is naturally line-granular.
  assign vs = (vcnt_q >= VW'(V_ACTIVE + V_FP)) &&
              (vcnt_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

  // Next-count logic: hcnt wraps each line, vcnt advances on the wrap.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (line_end) begin
      hcnt_d = '0;
      if (last_line_s) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/pattern_gen_multi.sv
// ---------------------------------------------------------------------------
// pattern_gen_multi
//   Programmable-timing test-pattern source for the rgb2dvi encoder.
//   Ports:
//     CLK, RST_N        : pixel clock, asynchronous active-low reset
//     MODE[1:0]         : 0 bars, 1 checker, 2 gradient, 3 solid (taken at
//                         the frame boundary only)
//     SOLID_RGB[3*CW-1:0]: {R,G,B} for solid mode, sampled live
//     VGA_R/G/B         : colour components, zero outside the active area
//     VGA_HS/VS/DE      : syncs (polarity by HS_POL/VS_POL) and data enable
//     FRAME_START       : one-cycle pulse with pixel (0,0)
//   All outputs are registered one clock after the counters.
//   Optional macro PATTERN_GEN_MULTI_SCROLL_EN: horizontal scroll of one
//   pixel per frame via an offset register.
// ---------------------------------------------------------------------------
module pattern_gen_multi
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CW         = 8,
  parameter int CHK_LOG2   = 5,
  parameter int GRAD_SHIFT = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [1:0]      MODE,
  input  logic [3*CW-1:0] SOLID_RGB,
  output logic [CW-1:0]   VGA_R,
  output logic [CW-1:0]   VGA_G,
  output logic [CW-1:0]   VGA_B,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_DE,
  output logic            FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  logic [HW-1:0] hcnt_s;
  logic [VW-1:0] vcnt_s;
  logic          active_s, h_active_s, hs_s, vs_s;
  logic          line_end_s, frame_end_s, frame_first_s;
  logic [HW-1:0] x_s;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(CLK), .rst_n(RST_N),
    .hcnt(hcnt_s), .vcnt(vcnt_s),
    .active(active_s), .h_active(h_active_s),
    .hs(hs_s), .vs(vs_s),
    .line_end(line_end_s), .frame_end(frame_end_s),
    .frame_first(frame_first_s)
  );

  // Advance the bar tracker by one pixel; index 7 absorbs any remainder.
  function automatic logic [HW+2:0] bar_step(input logic [2:0] idx,
                                             input logic [HW-1:0] pix);
    logic [HW+2:0] r;
    if (idx == 3'd7) begin
      r = {idx, pix};
    end else if (pix == HW'(BAR_W - 1)) begin
      r = {idx + 3'd1, HW'(0)};
    end else begin
      r = {idx, pix + HW'(1)};
    end
    return r;
  endfunction

  // ---------------- mode latch ----------------
  mode_e mode_q, mode_d;

  // Take MODE only at the frame boundary so a frame never mixes patterns.
  always_comb begin
    if (frame_end_s) begin
      mode_d = mode_e'(MODE);
    end else begin
      mode_d = mode_q;
    end
  end

  // ---------------- scroll / bar start state ----------------
  // Bar state that the bar tracker reloads at each line start (x of hcnt 0).
  logic [2:0]    bar_start_idx_s;
  logic [HW-1:0] bar_start_pix_s;

`ifdef PATTERN_GEN_MULTI_SCROLL_EN
  logic [HW-1:0] offset_q, offset_d;
  logic [2:0]    start_idx_q, start_idx_d;
  logic [HW-1:0] start_pix_q, start_pix_d;
  logic [HW:0]   x_sum_s;

  // Offset and the matching bar start state step together once per frame.
  always_comb begin
    offset_d    = offset_q;
    start_idx_d = start_idx_q;
    start_pix_d = start_pix_q;
    if (frame_end_s) begin
      if (offset_q == HW'(H_ACTIVE - 1)) begin
        offset_d    = '0;
        start_idx_d = 3'd0;
        start_pix_d = '0;
      end else begin
        offset_d                   = offset_q + HW'(1);
        {start_idx_d, start_pix_d} = bar_step(start_idx_q, start_pix_q);
      end
    end else begin
      offset_d = offset_q;
    end
  end

  // Scroll state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      offset_q    <= '0;
      start_idx_q <= 3'd0;
      start_pix_q <= '0;
    end else begin
      offset_q    <= offset_d;
      start_idx_q <= start_idx_d;
      start_pix_q <= start_pix_d;
    end
  end

  // Scrolled coordinate, wrapped into the active width.
  always_comb begin
    x_sum_s = {1'b0, hcnt_s} + {1'b0, offset_q};
    if (x_sum_s >= (HW+1)'(H_ACTIVE)) begin
      x_s = HW'(x_sum_s - (HW+1)'(H_ACTIVE));
    end else begin
      x_s = x_sum_s[HW-1:0];
    end
  end

  // The line after a frame boundary must see the freshly stepped start.
  assign bar_start_idx_s = start_idx_d;
  assign bar_start_pix_s = start_pix_d;
`else
  assign x_s             = hcnt_s;
  assign bar_start_idx_s = 3'd0;
  assign bar_start_pix_s = '0;
`endif

  // ---------------- bar tracker (replaces x / BAR_W) ----------------
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [HW-1:0] bar_pix_q, bar_pix_d;

  // Track which bar x falls in; reload at line end, wrap with x.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q;
    if (line_end_s) begin
      bar_idx_d = bar_start_idx_s;
      bar_pix_d = bar_start_pix_s;
    end else if (h_active_s) begin
      if (x_s == HW'(H_ACTIVE - 1)) begin
        bar_idx_d = 3'd0;
        bar_pix_d = '0;
      end else begin
        {bar_idx_d, bar_pix_d} = bar_step(bar_idx_q, bar_pix_q);
      end
    end else begin
      bar_idx_d = bar_idx_q;
    end
  end

  // ---------------- pattern datapath ----------------
  logic [3*CW-1:0] rgb_s;
  logic [2:0]      mask_s;
  logic            cell_s;
  logic [CW-1:0]   grad_s;

  // Select the pattern colour for the current pixel.
  always_comb begin
    rgb_s  = '0;
    mask_s = bar_mask(bar_idx_q);
    cell_s = x_s[CHK_LOG2] ^ vcnt_s[CHK_LOG2];
    grad_s = CW'(x_s >> GRAD_SHIFT);
    case (mode_q)
      MODE_BARS:  rgb_s = {{CW{mask_s[2]}}, {CW{mask_s[1]}}, {CW{mask_s[0]}}};
      MODE_CHECK: rgb_s = {(3*CW){cell_s}};
      MODE_GRAD:  rgb_s = {grad_s, grad_s, grad_s};
      MODE_SOLID: rgb_s = SOLID_RGB;
      default:    rgb_s = '0;
    endcase
  end

  // ---------------- output stage ----------------
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;

  // Blank colour outside the active area and apply sync polarity.
  always_comb begin
    if (active_s) begin
      rgb_d = rgb_s;
    end else begin
      rgb_d = '0;
    end
    de_d = active_s;
    hs_d = hs_s ? HS_POL : ~HS_POL;
    vs_d = vs_s ? VS_POL : ~VS_POL;
    fs_d = frame_first_s;
  end

  // Output, mode and bar-tracker registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rgb_q     <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      mode_q    <= MODE_BARS;
      bar_idx_q <= 3'd0;
      bar_pix_q <= '0;
    end else begin
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      mode_q    <= mode_d;
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
    end
  end

  assign VGA_R       = rgb_q[3*CW-1:2*CW];
  assign VGA_G       = rgb_q[2*CW-1:CW];
  assign VGA_B       = rgb_q[CW-1:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_DE      = de_q;
  assign FRAME_START = fs_q;

endmodule
